// File: rtl/jk2102_i2c_ppt_ctrl.sv
// Presentation-controller I2C slave: writes load an 8-bit control register on uo_out,
// reads return the ui_in buttons. SCL/SDA are oversampled by clk; SDA is open-drain.
module jk2102_i2c_ppt_ctrl #(
   parameter logic [6:0] I2C_ADDR = 7'h5A
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ADDR      = 3'd1;
   localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
   localparam logic [2:0] ST_WRITE     = 3'd3;
   localparam logic [2:0] ST_WRITE_ACK = 3'd4;
   localparam logic [2:0] ST_READ      = 3'd5;
   localparam logic [2:0] ST_READ_ACK  = 3'd6;
   localparam logic [2:0] ST_WAIT      = 3'd7;

   logic       scl_s1_reg, scl_s2_reg, scl_h_reg;
   logic       sda_s1_reg, sda_s2_reg, sda_h_reg;
   logic [2:0] state_reg;
   logic [2:0] bit_cnt_reg;
   logic       byte_done_reg;
   logic [7:0] shift_reg;
   logic [7:0] tx_reg;
   logic [7:0] ctrl_reg;
   logic       ack_reg;
   logic       sda_drive_reg;

   logic scl_rise, scl_fall, sda_rise, sda_fall;
   logic start_det, stop_det;

   wire unused = &{1'b0, ena, uio_in[7:2], 1'b0};

   assign scl_rise  =  scl_s2_reg & ~scl_h_reg;
   assign scl_fall  = ~scl_s2_reg &  scl_h_reg;
   assign sda_rise  =  sda_s2_reg & ~sda_h_reg;
   assign sda_fall  = ~sda_s2_reg &  sda_h_reg;
   assign start_det = sda_fall & scl_s2_reg;
   assign stop_det  = sda_rise & scl_s2_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_s1_reg    <= 1'b1;
         scl_s2_reg    <= 1'b1;
         scl_h_reg     <= 1'b1;
         sda_s1_reg    <= 1'b1;
         sda_s2_reg    <= 1'b1;
         sda_h_reg     <= 1'b1;
         state_reg     <= ST_IDLE;
         bit_cnt_reg   <= 3'd0;
         byte_done_reg <= 1'b0;
         shift_reg     <= 8'h00;
         tx_reg        <= 8'h00;
         ctrl_reg      <= 8'h00;
         ack_reg       <= 1'b1;
         sda_drive_reg <= 1'b0;
      end else begin
         scl_s1_reg <= uio_in[0];
         scl_s2_reg <= scl_s1_reg;
         scl_h_reg  <= scl_s2_reg;
         sda_s1_reg <= uio_in[1];
         sda_s2_reg <= sda_s1_reg;
         sda_h_reg  <= sda_s2_reg;

         if (start_det) begin
            state_reg     <= ST_ADDR;
            bit_cnt_reg   <= 3'd0;
            byte_done_reg <= 1'b0;
            sda_drive_reg <= 1'b0;
         end else if (stop_det) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 3'd0;
            byte_done_reg <= 1'b0;
            sda_drive_reg <= 1'b0;
         end else begin
            case (state_reg)
               // byte_done separates the 8th falling edge from the one right after START
               ST_ADDR: begin
                  if (scl_rise) begin
                     shift_reg   <= {shift_reg[6:0], sda_s2_reg};
                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
                     if (bit_cnt_reg == 3'd7) byte_done_reg <= 1'b1;
                  end else if (scl_fall && byte_done_reg) begin
                     byte_done_reg <= 1'b0;
                     if (shift_reg[7:1] == I2C_ADDR) begin
                        sda_drive_reg <= 1'b1;
                        state_reg     <= ST_ADDR_ACK;
                     end else begin
                        state_reg <= ST_WAIT;
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  if (scl_fall) begin
                     bit_cnt_reg <= 3'd0;
                     if (shift_reg[0]) begin
                        tx_reg        <= ui_in;
                        sda_drive_reg <= ~ui_in[7];
                        state_reg     <= ST_READ;
                     end else begin
                        sda_drive_reg <= 1'b0;
                        state_reg     <= ST_WRITE;
                     end
                  end
               end
               ST_WRITE: begin
                  if (scl_rise) begin
                     shift_reg   <= {shift_reg[6:0], sda_s2_reg};
                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
                     if (bit_cnt_reg == 3'd7) begin
                        ctrl_reg      <= {shift_reg[6:0], sda_s2_reg};
                        byte_done_reg <= 1'b1;
                     end
                  end else if (scl_fall && byte_done_reg) begin
                     byte_done_reg <= 1'b0;
                     sda_drive_reg <= 1'b1;
                     state_reg     <= ST_WRITE_ACK;
                  end
               end
               ST_WRITE_ACK: begin
                  if (scl_fall) begin
                     sda_drive_reg <= 1'b0;
                     state_reg     <= ST_WRITE;
                  end
               end
               ST_READ: begin
                  if (scl_rise) begin
                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
                     if (bit_cnt_reg == 3'd7) byte_done_reg <= 1'b1;
                  end else if (scl_fall) begin
                     if (byte_done_reg) begin
                        byte_done_reg <= 1'b0;
                        sda_drive_reg <= 1'b0;
                        state_reg     <= ST_READ_ACK;
                     end else begin
                        tx_reg        <= {tx_reg[6:0], 1'b0};
                        sda_drive_reg <= ~tx_reg[6];
                     end
                  end
               end
               ST_READ_ACK: begin
                  if (scl_rise) begin
                     ack_reg <= sda_s2_reg;
                  end else if (scl_fall) begin
                     if (!ack_reg) begin
                        tx_reg        <= ui_in;
                        sda_drive_reg <= ~ui_in[7];
                        bit_cnt_reg   <= 3'd0;
                        state_reg     <= ST_READ;
                     end else begin
                        state_reg <= ST_WAIT;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign uo_out  = ctrl_reg;
   assign uio_out = 8'h00;
   assign uio_oe  = {6'b000000, sda_drive_reg, 1'b0};

endmodule

// File: tb/tb_jk2102_i2c_ppt_ctrl.sv
// Directed bench for the I2C presentation controller: bit-banged master on a wired-AND SDA.
module tb_jk2102_i2c_ppt_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   logic scl_m = 1'b1;
   logic sda_m = 1'b1;
   logic sda_bus;

   int tests_run = 0;
   int tests_failed = 0;

   assign sda_bus = sda_m & ~uio_oe[1];
   assign uio_in  = {6'b000000, sda_bus, scl_m};

   always #5 clk = ~clk;

   jk2102_i2c_ppt_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("[TB] %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // SCL high with SDA high on entry; leaves SCL low
   task automatic i2c_start();
      sda_m = 1'b0;
      clks(6);
      scl_m = 1'b0;
      clks(2);
   endtask

   // SCL low on entry
   task automatic i2c_rep_start();
      clks(2);
      sda_m = 1'b1;
      clks(4);
      scl_m = 1'b1;
      clks(6);
      i2c_start();
   endtask

   task automatic i2c_stop();
      clks(2);
      sda_m = 1'b0;
      clks(4);
      scl_m = 1'b1;
      clks(6);
      sda_m = 1'b1;
      clks(6);
   endtask

   // One clock pulse; returns bus SDA and the slave pull-down seen late in SCL high
   task automatic i2c_bit(input logic b, output logic rd, output logic oe);
      clks(2);
      sda_m = b;
      clks(4);
      scl_m = 1'b1;
      clks(5);
      rd = sda_bus;
      oe = uio_oe[1];
      scl_m = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic rd, oe;
      for (int i = 7; i >= 0; i--) i2c_bit(b[i], rd, oe);
      i2c_bit(1'b1, rd, oe);
      ack = oe;
   endtask

   task automatic read_byte(output logic [7:0] d);
      logic rd, oe;
      for (int i = 7; i >= 0; i--) begin
         i2c_bit(1'b1, rd, oe);
         d[i] = rd;
      end
   endtask

   initial begin
      logic       ack, rd, oe;
      logic [7:0] rdata;

      clks(3);
      rst = 1'b0;
      clks(4);
      check("reset_uo_out", uo_out, 8'h00);
      check("reset_uio_oe", uio_oe, 8'h00);
      check("reset_uio_out", uio_out, 8'h00);

      // plain write 0xCD
      i2c_start();
      write_byte(8'hB4, ack);
      check("w1_addr_ack", {7'd0, ack}, 8'h01);
      write_byte(8'hCD, ack);
      check("w1_data_ack", {7'd0, ack}, 8'h01);
      check("w1_uo_out", uo_out, 8'hCD);
      i2c_stop();
      check("w1_oe_after_stop", uio_oe, 8'h00);

      // second write overwrites
      i2c_start();
      write_byte(8'hB4, ack);
      check("w2_addr_ack", {7'd0, ack}, 8'h01);
      write_byte(8'hEF, ack);
      check("w2_data_ack", {7'd0, ack}, 8'h01);
      i2c_stop();
      check("w2_uo_out", uo_out, 8'hEF);

      // write 0x03, repeated START, read buttons
      ui_in = 8'hA5;
      i2c_start();
      write_byte(8'hB4, ack);
      write_byte(8'h03, ack);
      check("w3_data_ack", {7'd0, ack}, 8'h01);
      i2c_rep_start();
      write_byte(8'hB5, ack);
      check("r_addr_ack", {7'd0, ack}, 8'h01);
      read_byte(rdata);
      check("r_data", rdata, 8'hA5);
      i2c_bit(1'b1, rd, oe);
      check("r_nack_oe", {7'd0, oe}, 8'h00);
      i2c_stop();
      check("r_oe_after_stop", uio_oe, 8'h00);
      check("r_uo_out", uo_out, 8'h03);

      // foreign address is ignored
      i2c_start();
      write_byte(8'h78, ack);
      check("bad_addr_ack", {7'd0, ack}, 8'h00);
      write_byte(8'h99, ack);
      check("bad_data_ack", {7'd0, ack}, 8'h00);
      i2c_stop();
      check("bad_uo_out", uo_out, 8'h03);

      // reset mid data byte
      i2c_start();
      write_byte(8'hB4, ack);
      i2c_bit(1'b1, rd, oe);
      i2c_bit(1'b0, rd, oe);
      i2c_bit(1'b1, rd, oe);
      rst = 1'b1;
      clks(1);
      check("rst_mid_oe", uio_oe, 8'h00);
      check("rst_mid_uo_out", uo_out, 8'h00);
      rst = 1'b0;
      i2c_stop();
      i2c_start();
      write_byte(8'hB4, ack);
      check("post_rst_addr_ack", {7'd0, ack}, 8'h01);
      write_byte(8'h55, ack);
      check("post_rst_data_ack", {7'd0, ack}, 8'h01);
      i2c_stop();
      check("post_rst_uo_out", uo_out, 8'h55);
      check("post_rst_oe", uio_oe, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/jk2102_i2c_ppt_ctrl.md
Name: jk2102_i2c_ppt_ctrl

Overview:
- TinyTapeout-style top for a presentation-controller peripheral: an I2C slave, 7-bit address 0x5A, oversampled by the system clock.
- An I2C write loads an 8-bit control register that drives uo_out.
- An I2C read returns the state of the ui_in button inputs.
- SCL and SDA come in on uio[0] and uio[1]; SDA is open-drain through uio_oe[1].

Parameters:
- I2C_ADDR, 7'h5A, slave address matched against the first byte after START.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  tile enable; ignored, design always active.
- ui_in  in  8  button/status inputs; returned on I2C read.
- uo_out  out  8  control register contents.
- uio_in  in  8  [0]=SCL, [1]=SDA; [7:2] unused.
- uio_out  out  8  constant 0; SDA is only ever driven low.
- uio_oe  out  8  [1]=1 pulls SDA low; all other bits constant 0.

Behaviour:
- Input conditioning
  - SCL and SDA each pass through a 2-flop synchronizer plus one history flop.
  - scl_rise / scl_fall / sda_rise / sda_fall are single-clk pulses.
  - Requirement: SCL high and low phases ≥ 4 clk each.
- Bus events
  - START: sda_fall while synchronized SCL=1.
  - STOP: sda_rise while SCL=1.
  - START from any state, including repeated START mid-transfer: clear the bit counter, go to ADDR.
  - STOP from any state: go to IDLE, release SDA.
- Data sampling and driving
  - Sample SDA on scl_rise.
  - Slave-driven SDA changes only on scl_fall.
  - Shift MSB first; 3-bit counter counts 8 bits.
- FSM states: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT.
  - IDLE: SDA released; wait for START.
  - ADDR: collect 8 bits (7-bit address + R/W).
    - On the 8th scl_fall: if address == I2C_ADDR, drive SDA low and go to ADDR_ACK.
    - Else go to WAIT (ignore bus until next START/STOP).
  - ADDR_ACK: hold SDA low through the ACK clock; on the next scl_fall release SDA.
    - R/W=0: go to WRITE.
    - R/W=1: capture ui_in into tx shift register, drive its MSB (low if 0), go to READ.
  - WRITE: collect 8 bits.
    - On the 8th scl_rise, load the control register (uo_out updates within 1 clk).
    - On the following scl_fall, drive ACK low and go to WRITE_ACK.
  - WRITE_ACK: on scl_fall release SDA, return to WRITE. Multi-byte writes overwrite the register; last byte wins.
  - READ: drive tx bits on each scl_fall; after the 8th bit release SDA on scl_fall and go to READ_ACK.
  - READ_ACK: sample master bit on scl_rise.
    - ACK (0): recapture ui_in and return to READ on scl_fall.
    - NACK (1): go to WAIT.
- SDA drive is open-drain
  - Drive low: uio_oe[1]=1.
  - Release: uio_oe[1]=0.
  - uio_out[1] always 0.
- Reset (synchronous, rst=1 at a clk edge)
  - uo_out=0, control register=0, state=IDLE, counters 0, uio_oe=0, synchronizers=1 (idle bus).
  - Reset mid-transfer aborts immediately and releases SDA in the same cycle.

Test Plan:
- Reset then idle bus (SCL=SDA=1): uo_out=0x00, uio_oe=0x00, uio_out=0x00.
- START, 0xB4 (0x5A+W), 0xCD, STOP: uio_oe[1]=1 during both ACK clocks; uo_out=0xCD after the 8th data bit.
- Second transaction START, 0xB4, 0xEF, STOP: uo_out=0xEF.
- Write 0x03 without STOP, then repeated START, 0xB5 (read), ui_in=0xA5, master clocks 8 bits then NACK, STOP:
  - uo_out=0x03.
  - Slave ACKs the address.
  - SDA read back on SCL high = 1,0,1,0,0,1,0,1.
  - uio_oe[1]=0 during the NACK bit and after STOP.
- START, address 0x3C+W, data: no ACK (uio_oe[1] stays 0); uo_out unchanged.
- Assert rst during the write data byte: SDA released next clk, uo_out=0; a following full write 0x55 succeeds.
